// File: rtl/inv_sub_bytes_seq_pkg.sv
// Shared FSM state type, state size and LANES legality check for the inverse SubBytes engine.
// Pure definitions; no latency or backpressure of its own.
package inv_sub_bytes_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STATE_BYTES = 16;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// AES inverse S-box, one byte, purely combinational (zero latency, no flow control).
// Table row r holds the results for inputs 0xr0..0xrf, leftmost byte first.
module InverseSbox (
  input  logic [7:0] value,
  output logic [7:0] sub
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign sub = INV_SBOX[value];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: LANES bytes per cycle, result NGRP edges after acceptance.
// One block in flight; in_ready only in IDLE, result held in DONE until out_ready.
module inv_sub_bytes_seq
  import inv_sub_bytes_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NGRP = STATE_BYTES / LANES;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int LW   = 8 * LANES;

  if (!lanes_legal(LANES)) begin : g_lanes_check
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_t          state;
  logic [GW-1:0]   grp;
  logic [127:0]    work;
  logic [LW-1:0]   grp_bytes;
  logic [LW-1:0]   sub_bytes;

  assign grp_bytes = work[int'(grp)*LW +: LW];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    InverseSbox u_sbox (
      .value (grp_bytes[8*l +: 8]),
      .sub   (sub_bytes[8*l +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grp   <= '0;
      work  <= '0;
    end else if (flush) begin
      state <= IDLE;
      grp   <= '0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            grp   <= '0;
            state <= SUB;
          end
        end
        SUB: begin
          // Only the current group is rewritten, so each byte is substituted exactly once.
          work[int'(grp)*LW +: LW] <= sub_bytes;
          if (grp == GW'(NGRP - 1)) begin
            grp   <= '0;
            state <= DONE;
          end else begin
            grp <= grp + GW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq with LANES = 4, 1 and 16 instances.
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic         iv4 = 1'b0, iv1 = 1'b0, iv16 = 1'b0;
  logic         ir4, ir1, ir16, ov4, ov1, ov16, busy4, busy1, busy16;
  logic [127:0] os4, os1, os16;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] INCR_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] INCR_OUT = 128'hfbd7f3819ea340bf38a53630d56a0952;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv4), .in_ready(ir4),
    .in_state(in_state), .out_valid(ov4), .out_ready(out_ready), .out_state(os4), .busy(busy4));

  inv_sub_bytes_seq #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
    .in_state(in_state), .out_valid(ov1), .out_ready(out_ready), .out_state(os1), .busy(busy1));

  inv_sub_bytes_seq #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv16), .in_ready(ir16),
    .in_state(in_state), .out_valid(ov16), .out_ready(out_ready), .out_state(os16), .busy(busy16));

  function automatic logic ov_of(input int which);
    return (which == 0) ? ov4 : (which == 1) ? ov1 : ov16;
  endfunction

  // Called #1 after a posedge with the target idle; returns #1 after the acceptance edge.
  task automatic send(input int which, input logic [127:0] d);
    in_state = d;
    iv4  = (which == 0);
    iv1  = (which == 1);
    iv16 = (which == 2);
    @(posedge clk); #1;
    iv4 = 1'b0; iv1 = 1'b0; iv16 = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid, bounded at 40.
  task automatic wait_done(input int which, output int lat);
    lat = 0;
    while (!ov_of(which) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir4); end
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
    checks++; if ({ov1, ov16, busy1, busy16} !== 4'b0) begin errors++; $display("FAIL reset_other_lanes got %b want 0000", {ov1, ov16, busy1, busy16}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat;
    send(0, '0);
    checks++; if (busy4 !== 1'b1 || ir4 !== 1'b0) begin errors++; $display("FAIL zero_busy_after_accept got busy=%b in_ready=%b want 1/0", busy4, ir4); end
    wait_done(0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL zero_latency got %0d want 4", lat); end
    checks++; if (os4 !== {16{8'h52}}) begin errors++; $display("FAIL zero_result got %h want %h", os4, {16{8'h52}}); end
    drain();
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL zero_after_handshake got out_valid=%b in_ready=%b want 0/1", ov4, ir4); end
  endtask

  task automatic test_incr();
    int lat;
    send(0, INCR_IN);
    wait_done(0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL incr_latency got %0d want 4", lat); end
    checks++; if (os4 !== INCR_OUT) begin errors++; $display("FAIL incr_result got %h want %h", os4, INCR_OUT); end
    drain();
  endtask

  task automatic test_hold();
    int lat;
    send(0, {16{8'h63}});
    wait_done(0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL hold_latency got %0d want 4", lat); end
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        in_state = {16{8'h11}};
        iv4 = 1'b1;
      end
      checks++;
      if (ov4 !== 1'b1 || os4 !== '0 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got out_valid=%b in_ready=%b out_state=%h want 1/0/0", i, ov4, ir4, os4);
      end
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    drain();
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL hold_release got out_valid=%b in_ready=%b want 0/1", ov4, ir4); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL hold_ignored_input got busy=%b want 0", busy4); end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    send(0, {16{8'h5a}});
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL flush_state got in_ready=%b out_valid=%b busy=%b want 1/0/0", ir4, ov4, busy4); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ov4) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_out_valid got %0d cycles want 0", seen); end
    send(0, {16{8'hff}});
    wait_done(0, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL flush_next_latency got %0d want 4", lat); end
    checks++; if (os4 !== {16{8'h7d}}) begin errors++; $display("FAIL flush_next_result got %h want %h", os4, {16{8'h7d}}); end
    drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    send(0, INCR_IN);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rstmid_async got in_ready=%b out_valid=%b busy=%b want 1/0/0", ir4, ov4, busy4); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ov4 || busy4) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_stale got %0d active cycles want 0", seen); end
  endtask

  task automatic test_lanes1();
    int lat;
    send(1, INCR_IN);
    wait_done(1, lat);
    checks++; if (lat != 16) begin errors++; $display("FAIL lanes1_latency got %0d want 16", lat); end
    checks++; if (os1 !== INCR_OUT) begin errors++; $display("FAIL lanes1_result got %h want %h", os1, INCR_OUT); end
    drain();
  endtask

  task automatic test_lanes16();
    int lat;
    send(2, INCR_IN);
    wait_done(2, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL lanes16_latency got %0d want 1", lat); end
    checks++; if (os16 !== INCR_OUT) begin errors++; $display("FAIL lanes16_result got %h want %h", os16, INCR_OUT); end
    drain();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_incr();
    test_hold();
    test_flush();
    test_reset_mid();
    test_lanes1();
    test_lanes16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
